wf_slot_allocator: RTL and testbench

Tracks occupancy of the 40 wavefront slots in a compute unit and hands out the lowest-index free slot to the dispatcher.
- Upstream of the lowest-set-bit priority encoder: builds and holds the 40-bit free mask the encoder consumes, then registers the encoder result as the granted slot ID.
- Slots are returned by the wavefront-completion path.
- Sits between the dispatcher interface and the wavepool/issue bookkeeping.

---
 rtl/wf_slot_allocator_pkg.sv | 13 +
 rtl/wf_slot_allocator_encoder.sv | 23 ++
 rtl/wf_slot_allocator.sv | 114 +++++++++++
 tb/tb_wf_slot_allocator.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/wf_slot_allocator_pkg.sv
// Shared definitions for the wavefront slot allocator: slot count, slot ID width
// and the two-state grant handshake encoding.
package wf_slot_allocator_pkg;

   localparam int NUM_WF_SLOTS = 40;
   localparam int WF_SLOT_W    = 6;

   typedef enum logic {
      IDLE = 1'b0,
      ACK  = 1'b1
   } wf_state_e;

endpackage

// File: rtl/wf_slot_allocator_encoder.sv
// 40-to-6 lowest-index priority encoder: o_idx is the position of the lowest set
// bit of i_req, o_valid flags that at least one bit is set.
module encoder
   import wf_slot_allocator_pkg::*;
(
   input  logic [NUM_WF_SLOTS-1:0] i_req,
   output logic [WF_SLOT_W-1:0]    o_idx,
   output logic                    o_valid
);

   // Scan from the top so the last hit written is the lowest index.
   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      for (int i = NUM_WF_SLOTS - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_idx   = WF_SLOT_W'(i);
            o_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/wf_slot_allocator.sv
// Wavefront slot allocator: tracks 40-slot occupancy and grants the lowest free slot.
// Optional sticky illegal-use flag dealloc_err is built when WF_SLOT_ERR_CHK_EN is defined.
module wf_slot_allocator
   import wf_slot_allocator_pkg::*;
#(
   parameter int NUM_SLOTS = NUM_WF_SLOTS,
   parameter int SLOT_W    = WF_SLOT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 alloc_req,
   output logic                 alloc_ack,
   output logic [SLOT_W-1:0]    alloc_slot,
   input  logic                 dealloc_valid,
   input  logic [SLOT_W-1:0]    dealloc_slot,
   output logic [NUM_SLOTS-1:0] busy_mask,
   output logic [SLOT_W-1:0]    free_count,
   output logic                 full
`ifdef WF_SLOT_ERR_CHK_EN
  ,output logic                 dealloc_err
`endif
);

   wf_state_e             r_state;
   logic                  r_ack;
   logic [SLOT_W-1:0]     r_slot;
   logic [NUM_SLOTS-1:0]  r_busy;
   logic [SLOT_W-1:0]     r_free;
   logic                  r_full;

   logic [SLOT_W-1:0]     w_enc_idx;
   logic                  w_enc_valid;
   logic                  w_grant;
   logic                  w_dealloc_in_range;
   logic [NUM_SLOTS-1:0]  w_grant_oh;
   logic [NUM_SLOTS-1:0]  w_dealloc_oh;
   logic                  w_dealloc_ok;
   logic [SLOT_W-1:0]     w_free_nxt;

   // Search only the registered mask; a slot returned this cycle waits a cycle.
   encoder u_encoder (
      .i_req   (~r_busy),
      .o_idx   (w_enc_idx),
      .o_valid (w_enc_valid)
   );

   assign w_grant            = (r_state == IDLE) && alloc_req && !r_full && w_enc_valid;
   assign w_grant_oh         = w_grant ? (NUM_SLOTS'(1) << w_enc_idx) : '0;
   assign w_dealloc_in_range = dealloc_valid && (dealloc_slot < SLOT_W'(NUM_SLOTS));
   assign w_dealloc_oh       = w_dealloc_in_range ? ((NUM_SLOTS'(1) << dealloc_slot) & r_busy) : '0;
   assign w_dealloc_ok       = |w_dealloc_oh;
   assign w_free_nxt         = r_free - SLOT_W'(w_grant) + SLOT_W'(w_dealloc_ok);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_ack   <= 1'b0;
         r_slot  <= '0;
         r_busy  <= '0;
         r_free  <= SLOT_W'(NUM_SLOTS);
         r_full  <= 1'b0;
      end else begin
         r_busy <= (r_busy | w_grant_oh) & ~w_dealloc_oh;
         r_free <= w_free_nxt;
         r_full <= (w_free_nxt == '0);
         case (r_state)
            IDLE: begin
               r_ack <= 1'b0;
               if (w_grant) begin
                  r_slot  <= w_enc_idx;
                  r_ack   <= 1'b1;
                  r_state <= ACK;
               end
            end
            ACK: begin
               r_ack   <= 1'b0;
               r_state <= IDLE;
            end
            default: begin
               r_ack   <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

`ifdef WF_SLOT_ERR_CHK_EN
   logic r_pend;
   logic r_err;

   // r_pend marks a request that was seen in IDLE but could not be granted yet.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         r_pend <= (r_state == IDLE) && alloc_req && !w_grant;
         if ((dealloc_valid && !w_dealloc_ok) ||
             ((r_state == IDLE) && r_pend && !alloc_req)) begin
            r_err <= 1'b1;
         end
      end
   end

   assign dealloc_err = r_err;
`endif

   assign alloc_ack  = r_ack;
   assign alloc_slot = r_slot;
   assign busy_mask  = r_busy;
   assign free_count = r_free;
   assign full       = r_full;

endmodule

// File: tb/tb_wf_slot_allocator.sv
// Directed and randomized self-checking bench for wf_slot_allocator.
// Build with WF_SLOT_ERR_CHK_EN to also check the sticky dealloc_err flag.
module tb_wf_slot_allocator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alloc_req = 1'b0;
   logic        alloc_ack;
   logic [5:0]  alloc_slot;
   logic        dealloc_valid = 1'b0;
   logic [5:0]  dealloc_slot = '0;
   logic [39:0] busy_mask;
   logic [5:0]  free_count;
   logic        full;
`ifdef WF_SLOT_ERR_CHK_EN
   logic        dealloc_err;
`endif

   int total = 0;
   int bad   = 0;

   wf_slot_allocator dut (
      .clk           (clk),
      .rst           (rst),
      .alloc_req     (alloc_req),
      .alloc_ack     (alloc_ack),
      .alloc_slot    (alloc_slot),
      .dealloc_valid (dealloc_valid),
      .dealloc_slot  (dealloc_slot),
      .busy_mask     (busy_mask),
      .free_count    (free_count),
      .full          (full)
`ifdef WF_SLOT_ERR_CHK_EN
     ,.dealloc_err   (dealloc_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [39:0] held;
   int          id;

   initial begin
      // Reset state
      cycle();
      cycle();
      rst = 1'b0;
      chk("rst_busy", 64'(busy_mask), 64'h0);
      chk("rst_free", 64'(free_count), 64'd40);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_ack", 64'(alloc_ack), 64'd0);
      chk("rst_slot", 64'(alloc_slot), 64'd0);

      // Fill all 40 slots with the request held high
      alloc_req = 1'b1;
      for (int i = 0; i < 40; i++) begin
         cycle();
         chk("fill_ack", 64'(alloc_ack), 64'd1);
         chk("fill_slot", 64'(alloc_slot), 64'(i));
         chk("fill_free", 64'(free_count), 64'(39 - i));
         cycle();
         chk("fill_gap", 64'(alloc_ack), 64'd0);
      end
      chk("full_busy", 64'(busy_mask), 64'hFF_FFFF_FFFF);
      chk("full_free", 64'(free_count), 64'd0);
      chk("full_flag", 64'(full), 64'd1);
      cycle();
      chk("full_noack", 64'(alloc_ack), 64'd0);
      chk("full_slot_hold", 64'(alloc_slot), 64'd39);

      // Return slot 17 while full; the pending request picks it up a cycle later
      dealloc_valid = 1'b1;
      dealloc_slot  = 6'd17;
      cycle();
      dealloc_valid = 1'b0;
      chk("d17_ack0", 64'(alloc_ack), 64'd0);
      chk("d17_free", 64'(free_count), 64'd1);
      chk("d17_full", 64'(full), 64'd0);
      chk("d17_busy", 64'(busy_mask), 64'hFF_FFFD_FFFF);
      cycle();
      chk("d17_ack1", 64'(alloc_ack), 64'd1);
      chk("d17_slot", 64'(alloc_slot), 64'd17);
      chk("d17_refull", 64'(full), 64'd1);
      alloc_req = 1'b0;
      cycle();

      // Slots 0-9 busy, then grant and dealloc 3 on the same edge
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      alloc_req = 1'b1;
      for (int i = 0; i < 10; i++) begin
         cycle();
         chk("ten_slot", 64'(alloc_slot), 64'(i));
         cycle();
      end
      chk("ten_busy", 64'(busy_mask), 64'h3FF);
      dealloc_valid = 1'b1;
      dealloc_slot  = 6'd3;
      cycle();
      dealloc_valid = 1'b0;
      chk("sim_ack", 64'(alloc_ack), 64'd1);
      chk("sim_slot", 64'(alloc_slot), 64'd10);
      chk("sim_free", 64'(free_count), 64'd30);
      chk("sim_busy", 64'(busy_mask), 64'h7F7);
      cycle();
      chk("sim_gap", 64'(alloc_ack), 64'd0);
      cycle();
      chk("sim_next_ack", 64'(alloc_ack), 64'd1);
      chk("sim_next_slot", 64'(alloc_slot), 64'd3);
      chk("sim_next_free", 64'(free_count), 64'd29);
      alloc_req = 1'b0;
      cycle();
`ifdef WF_SLOT_ERR_CHK_EN
      chk("err_clean", 64'(dealloc_err), 64'd0);
`endif

      // Illegal deallocs: already-free slot 25 and out-of-range ID 45
      dealloc_valid = 1'b1;
      dealloc_slot  = 6'd25;
      cycle();
      chk("free25_busy", 64'(busy_mask), 64'h7FF);
      chk("free25_cnt", 64'(free_count), 64'd29);
`ifdef WF_SLOT_ERR_CHK_EN
      chk("free25_err", 64'(dealloc_err), 64'd1);
`endif
      dealloc_slot = 6'd45;
      cycle();
      dealloc_valid = 1'b0;
      chk("id45_busy", 64'(busy_mask), 64'h7FF);
      chk("id45_cnt", 64'(free_count), 64'd29);
      cycle();
      cycle();
`ifdef WF_SLOT_ERR_CHK_EN
      chk("err_sticky", 64'(dealloc_err), 64'd1);
`endif

      // Reset on the edge that would accept a request
      alloc_req = 1'b1;
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      alloc_req = 1'b0;
      chk("rstacc_ack", 64'(alloc_ack), 64'd0);
      chk("rstacc_busy", 64'(busy_mask), 64'h0);
      chk("rstacc_free", 64'(free_count), 64'd40);
      chk("rstacc_full", 64'(full), 64'd0);
`ifdef WF_SLOT_ERR_CHK_EN
      chk("rstacc_err", 64'(dealloc_err), 64'd0);
`endif

      // Random alloc/dealloc mix against an independent ownership set
      held = '0;
      for (int c = 0; c < 10000; c++) begin
         cycle();
         if (alloc_ack) begin
            chk("rnd_dup_grant", 64'(held[alloc_slot]), 64'd0);
            held[alloc_slot] = 1'b1;
            alloc_req = 1'b0;
         end else if (!alloc_req) begin
            alloc_req = ($urandom_range(1, 0) == 1);
         end
         chk("rnd_busy", 64'(busy_mask), 64'(held));
         chk("rnd_free", 64'(free_count), 64'(40 - $countones(busy_mask)));
         chk("rnd_full", 64'(full), 64'(held == 40'hFF_FFFF_FFFF));
         dealloc_valid = 1'b0;
         if ($urandom_range(2, 0) == 0) begin
            id = int'($urandom_range(47, 0));
            dealloc_valid = 1'b1;
            dealloc_slot  = 6'(id);
            if (id < 40 && held[id]) held[id] = 1'b0;
         end
      end
      dealloc_valid = 1'b0;
      alloc_req = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
